// File: rtl/spectrum_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// spectrum_peak_finder_pkg
// Constants and types shared by the spectral peak finder and the downstream
// frequency-conversion stage.
//   NFFT_MIN / NFFT_MAX : legal range of log2(N) on curr_nfft
//   NFFT_DEFAULT        : log2(N) used when curr_nfft is out of range
//   FS_HZ               : sample rate, so bin -> Hz is index * FS_HZ / N
//   state_t             : frame scan FSM states
//   effective_nfft()    : clamps a requested log2(N) to a supported one
// -----------------------------------------------------------------------------
package spectrum_peak_finder_pkg;

  localparam int NFFT_MIN     = 7;
  localparam int NFFT_MAX     = 10;
  localparam int NFFT_DEFAULT = 10;
  localparam int FS_HZ        = 48000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  // Out-of-range sizes fall back to the largest transform.
  function automatic logic [3:0] effective_nfft(input logic [4:0] nfft);
    if ((nfft >= 5'(NFFT_MIN)) && (nfft <= 5'(NFFT_MAX))) begin
      return nfft[3:0];
    end
    return 4'(NFFT_DEFAULT);
  endfunction

endpackage

// File: rtl/spectrum_peak_finder_mag_sq_pipe.sv
// -----------------------------------------------------------------------------
// mag_sq_pipe
// Two-stage signed magnitude-squared pipeline: stage 1 registers re^2 and
// im^2, stage 2 registers their unsigned sum. A valid/index sideband travels
// alongside so the consumer knows which bin each magnitude belongs to.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_index : sideband entering with the sample
//   re, im             : signed sample components
//   out_valid          : out_mag/out_index hold a new result
//   out_index          : bin index of that result
//   out_mag            : re^2 + im^2, unsigned, 2*DATA_W bits
// -----------------------------------------------------------------------------
module mag_sq_pipe #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_index,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_index,
  output logic [2*DATA_W-1:0]      out_mag
);

  // Operands are widened before the multiply so (-2^(DATA_W-1))^2 is exact.
  logic signed [2*DATA_W-1:0] re_ext;
  logic signed [2*DATA_W-1:0] im_ext;
  logic signed [2*DATA_W-1:0] re_sq_q;
  logic signed [2*DATA_W-1:0] im_sq_q;
  logic [IDX_W-1:0]           idx1_q;
  logic                       valid1_q;

  assign re_ext = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_ext = {{DATA_W{im[DATA_W-1]}}, im};

  // Only the valid bits need reset: a flushed pipeline must not emit a stale
  // result, while the data path is meaningless without its valid.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // values from before the edge; blocking (=) would chain stages in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      valid1_q  <= in_valid;
      out_valid <= valid1_q;
    end
  end

  // NOTE: datapath registers are deliberately left out of reset; they are
  // qualified by the valid bits above and reset-free flops map cleanly into
  // the DSP slice pipeline registers.
  always_ff @(posedge clk) begin
    re_sq_q   <= re_ext * re_ext;
    im_sq_q   <= im_ext * im_ext;
    idx1_q    <= in_index;
    // Each square is at most 2^(2*DATA_W-2), so the sum cannot overflow.
    out_mag   <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
    out_index <= idx1_q;
  end

endmodule

// File: rtl/spectrum_peak_finder.sv
// -----------------------------------------------------------------------------
// spectrum_peak_finder
// Scans one FFT output frame per pass and reports the strongest bin in the
// positive-frequency half (MIN_BIN .. N/2-1) with its magnitude-squared.
//   clk, rst     : clock, synchronous active-high reset
//   curr_nfft    : log2(N), 7..10 (others mean 10), sampled on first beat
//   s_re, s_im   : signed bin value; s_valid/s_ready handshake, s_last = EOF
//   max_index    : winning bin of the last completed frame
//   max_mag      : its re^2+im^2
//   max_valid    : one-cycle pulse when the outputs above are refreshed
//   frame_err    : last completed frame length differed from N
// A frame ends on s_last or on bin N-1, whichever comes first; the block then
// stalls four cycles while the magnitude/compare pipeline drains, publishes,
// and accepts the next frame.
// -----------------------------------------------------------------------------
module spectrum_peak_finder
  import spectrum_peak_finder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 10,
  parameter int MIN_BIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               curr_nfft,
  input  logic signed [DATA_W-1:0] s_re,
  input  logic signed [DATA_W-1:0] s_im,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [IDX_W-1:0]         max_index,
  output logic [2*DATA_W-1:0]      max_mag,
  output logic                     max_valid,
  output logic                     frame_err
);

  state_t state;
  state_t next_state;

  logic [3:0]          nfft_q;
  logic [3:0]          nfft_cur;
  logic [IDX_W-1:0]    next_bin;
  logic [IDX_W-1:0]    bin_k;
  logic [IDX_W-1:0]    last_bin;
  logic [IDX_W-1:0]    half_last;
  logic [1:0]          drain_cnt;
  logic                err_q;
  logic [2*DATA_W-1:0] best_mag;
  logic [IDX_W-1:0]    best_idx;

  logic accept_ok;
  logic beat;
  logic first_beat;
  logic is_last_bin;
  logic frame_end;
  logic in_window;
  logic publish_load;

  logic                pipe_valid;
  logic [IDX_W-1:0]    pipe_index;
  logic [2*DATA_W-1:0] pipe_mag;

  // ---------------------------------------------------------------------------
  // Beat bookkeeping
  // ---------------------------------------------------------------------------
  // Ready is gated by rst so no beat is taken while reset is being applied.
  assign accept_ok  = ((state == IDLE) || (state == RUN)) && !rst;
  assign s_ready    = accept_ok;
  assign beat       = s_valid && accept_ok;
  assign first_beat = beat && (state == IDLE);

  // The first beat of a frame uses curr_nfft directly; later beats use the
  // latched copy so mid-frame changes are ignored.
  assign nfft_cur  = (state == IDLE) ? effective_nfft(curr_nfft) : nfft_q;
  assign bin_k     = (state == IDLE) ? '0 : next_bin;
  assign last_bin  = IDX_W'((32'd1 << nfft_cur) - 32'd1);
  assign half_last = last_bin >> 1;

  assign is_last_bin = (bin_k == last_bin);
  assign frame_end   = beat && (s_last || is_last_bin);
  assign in_window   = (bin_k >= IDX_W'(MIN_BIN)) && (bin_k <= half_last);

  // Final beat enters P1 on edge E, its sum is out of P2 after E+1 and the
  // best register holds it after E+2; outputs load on E+3 (third DRAIN cycle).
  assign publish_load = (state == DRAIN) && (drain_cnt == 2'd2);

  // ---------------------------------------------------------------------------
  // Magnitude pipeline (P1 squares, P2 sum). Out-of-window beats never enter.
  // ---------------------------------------------------------------------------
  mag_sq_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mag_sq_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat && in_window),
    .in_index  (bin_k),
    .re        (s_re),
    .im        (s_im),
    .out_valid (pipe_valid),
    .out_index (pipe_index),
    .out_mag   (pipe_mag)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    max_valid  = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (beat) begin
          next_state = frame_end ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) begin
          next_state = PUBLISH;
        end
      end
      PUBLISH: begin
        max_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, error flag, P3 best register and published outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      nfft_q    <= 4'(NFFT_DEFAULT);
      next_bin  <= '0;
      drain_cnt <= 2'd0;
      err_q     <= 1'b0;
      best_mag  <= '0;
      best_idx  <= IDX_W'(MIN_BIN);
      max_index <= '0;
      max_mag   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (beat) begin
        next_bin <= bin_k + 1'b1;
      end
      if (first_beat) begin
        nfft_q <= nfft_cur;
      end

      // Error is decided once, on the beat that ends the frame: s_last and
      // "this is bin N-1" must coincide.
      if (frame_end) begin
        err_q <= (s_last != is_last_bin);
      end else if (first_beat) begin
        err_q <= 1'b0;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

      // Strict greater-than keeps the lowest index on ties; starting from
      // (MIN_BIN, 0) makes an all-zero window report MIN_BIN.
      if (first_beat) begin
        best_mag <= '0;
        best_idx <= IDX_W'(MIN_BIN);
      end else if (pipe_valid && (pipe_mag > best_mag)) begin
        best_mag <= pipe_mag;
        best_idx <= pipe_index;
      end

      if (publish_load) begin
        max_index <= best_idx;
        max_mag   <= best_mag;
        frame_err <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_spectrum_peak_finder
// Self-checking bench for spectrum_peak_finder. A frame-level reference model
// computes the expected peak, magnitude and length error from the stimulus
// arrays; published results are captured by a monitor and compared per test.
// -----------------------------------------------------------------------------
module tb_spectrum_peak_finder;
  import spectrum_peak_finder_pkg::*;

  localparam int DATA_W  = 16;
  localparam int IDX_W   = 10;
  localparam int MIN_BIN = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [4:0]               curr_nfft = 5'd10;
  logic signed [DATA_W-1:0] s_re = '0;
  logic signed [DATA_W-1:0] s_im = '0;
  logic                     s_valid = 1'b0;
  logic                     s_last = 1'b0;
  logic                     s_ready;
  logic [IDX_W-1:0]         max_index;
  logic [2*DATA_W-1:0]      max_mag;
  logic                     max_valid;
  logic                     frame_err;

  spectrum_peak_finder #(
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .MIN_BIN (MIN_BIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .curr_nfft (curr_nfft),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .max_index (max_index),
    .max_mag   (max_mag),
    .max_valid (max_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     idx;
    longint mag;
    bit     err;
    int     cyc;
  } pub_t;

  pub_t pubs[$];

  // Every cycle with max_valid high is one publish event.
  always @(negedge clk) begin
    pub_t t;
    if (max_valid === 1'b1) begin
      t.idx = int'(max_index);
      t.mag = longint'({32'b0, max_mag});
      t.err = (frame_err === 1'b1);
      t.cyc = cyc;
      pubs.push_back(t);
    end
  end

  logic signed [DATA_W-1:0] re_arr [2][1024];
  logic signed [DATA_W-1:0] im_arr [2][1024];

  // ---------------------------------------------------------------------------
  // Reference model: frame length, window search, length error.
  // ---------------------------------------------------------------------------
  task automatic model_frame(input int slot, input logic [4:0] nfft, input int last_pos,
                             output int len, output int e_idx, output longint e_mag,
                             output bit e_err);
    int nf;
    int n;
    longint r;
    longint i;
    longint m;
    nf = int'(nfft);
    n = (nf >= 7 && nf <= 10) ? (1 << nf) : 1024;
    len = (last_pos >= 0 && last_pos < n) ? last_pos + 1 : n;
    e_err = (last_pos != n - 1);
    e_idx = MIN_BIN;
    e_mag = 0;
    for (int k = MIN_BIN; k < len && k <= n / 2 - 1; k++) begin
      r = longint'(re_arr[slot][k]);
      i = longint'(im_arr[slot][k]);
      m = r * r + i * i;
      if (m > e_mag) begin
        e_mag = m;
        e_idx = k;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic fill(input int slot, input int mode);
    int v;
    for (int k = 0; k < 1024; k++) begin
      case (mode)
        0: begin re_arr[slot][k] = '0; im_arr[slot][k] = '0; end
        1: begin
          v = int'($urandom_range(0, 6)) - 3;
          re_arr[slot][k] = 16'(v);
          v = int'($urandom_range(0, 6)) - 3;
          im_arr[slot][k] = 16'(v);
        end
        default: begin
          re_arr[slot][k] = 16'($urandom);
          im_arr[slot][k] = 16'($urandom);
        end
      endcase
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drive_beat(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                            input bit last, input logic [4:0] nfft,
                            output int acc_cyc, output int waited);
    waited = 0;
    @(negedge clk);
    s_valid   = 1'b1;
    s_re      = re;
    s_im      = im;
    s_last    = last;
    curr_nfft = nfft;
    while (s_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_accept timeout: s_ready=%b after %0d cycles, want 1", s_ready, waited);
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic drive_frame(input int slot, input logic [4:0] nfft, input int last_pos,
                             input int len, input bit gaps, input bit scramble,
                             output int last_acc, output int first_wait);
    int w;
    logic [4:0] nf;
    last_acc = 0;
    first_wait = 0;
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      nf = (k == 0 || !scramble) ? nfft : 5'($urandom_range(0, 31));
      drive_beat(re_arr[slot][k], im_arr[slot][k], (k == last_pos), nf, last_acc, w);
      if (k == 0) first_wait = w;
    end
  endtask

  task automatic collect(output bit ok, output pub_t p);
    int n;
    n = 0;
    while (pubs.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (pubs.size() != 0);
    p = '{0, 0, 1'b0, 0};
    if (ok) p = pubs.pop_front();
  endtask

  // Drives one frame, then measures the stall and returns the publish.
  task automatic run_frame(input int slot, input logic [4:0] nfft, input int last_pos,
                           input bit gaps, input bit scramble,
                           output pub_t p, output bit ok, output int lat, output int low,
                           output int e_idx, output longint e_mag, output bit e_err);
    int len;
    int acc;
    int fw;
    model_frame(slot, nfft, last_pos, len, e_idx, e_mag, e_err);
    drive_frame(slot, nfft, last_pos, len, gaps, scramble, acc, fw);
    idle();
    low = 0;
    while (s_ready === 1'b0 && low < 20) begin
      low++;
      @(negedge clk);
    end
    collect(ok, p);
    lat = ok ? p.cyc - acc : -1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", s_ready); end
    checks++; if (max_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", max_valid); end
    checks++; if (max_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", max_index); end
    checks++; if (max_mag !== '0) begin errors++; $display("FAIL reset_mag got %0d want 0", max_mag); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", s_ready); end
  endtask

  task automatic test_single_tone();
    pub_t p; bit ok; int lat, low, ei, hz; longint em; bit ee;
    fill(0, 0);
    re_arr[0][21] = 16'sd1000;
    run_frame(0, 5'd10, 1023, 1'b0, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL tone_publish timeout: no max_valid"); end
    checks++; if (p.idx !== 21) begin errors++; $display("FAIL tone_index got %0d want 21", p.idx); end
    checks++; if (p.mag !== 64'd1000000) begin errors++; $display("FAIL tone_mag got %0d want 1000000", p.mag); end
    checks++; if (p.err !== 1'b0) begin errors++; $display("FAIL tone_err got %b want 0", p.err); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL tone_latency got %0d edges want 3", lat); end
    checks++; if (low !== 4) begin errors++; $display("FAIL tone_stall got %0d cycles want 4", low); end
    hz = (p.idx * FS_HZ) / 1024;
    checks++; if (hz !== 984) begin errors++; $display("FAIL tone_hz got %0d want 984", hz); end
  endtask

  task automatic test_dc_negative();
    pub_t p; bit ok; int lat, low, ei; longint em; bit ee;
    fill(0, 0);
    re_arr[0][0]   = 16'sd30000;
    re_arr[0][200] = 16'sd20000;
    re_arr[0][50]  = 16'sd500;
    run_frame(0, 5'd8, 255, 1'b1, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL dc_publish timeout: no max_valid"); end
    checks++; if (p.idx !== 50) begin errors++; $display("FAIL dc_index got %0d want 50", p.idx); end
    checks++; if (p.mag !== 64'd250000) begin errors++; $display("FAIL dc_mag got %0d want 250000", p.mag); end
    checks++; if (p.err !== 1'b0) begin errors++; $display("FAIL dc_err got %b want 0", p.err); end
  endtask

  task automatic test_tie_extreme();
    pub_t p; bit ok; int lat, low, ei; longint em; bit ee;
    fill(0, 0);
    re_arr[0][5] = -16'sd32768; im_arr[0][5] = -16'sd32768;
    re_arr[0][9] = -16'sd32768; im_arr[0][9] = -16'sd32768;
    run_frame(0, 5'd7, 127, 1'b0, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL tie_publish timeout: no max_valid"); end
    checks++; if (p.idx !== 5) begin errors++; $display("FAIL tie_index got %0d want 5", p.idx); end
    checks++; if (p.mag !== 64'd2147483648) begin errors++; $display("FAIL tie_mag got %0d want 2147483648", p.mag); end
    checks++; if (p.err !== 1'b0) begin errors++; $display("FAIL tie_err got %b want 0", p.err); end
  endtask

  task automatic test_len_err_short();
    pub_t p; bit ok; int lat, low, ei; longint em; bit ee;
    fill(0, 2);
    run_frame(0, 5'd8, 99, 1'b1, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL short_publish timeout: no max_valid"); end
    checks++; if (p.err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", p.err); end
    checks++; if (p.idx !== ei) begin errors++; $display("FAIL short_index got %0d want %0d", p.idx, ei); end
    checks++; if (p.mag !== em) begin errors++; $display("FAIL short_mag got %0d want %0d", p.mag, em); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL short_latency got %0d edges want 3", lat); end
  endtask

  task automatic test_len_err_forced();
    pub_t p; bit ok; int lat, low, ei; longint em; bit ee;
    fill(0, 2);
    run_frame(0, 5'd7, -1, 1'b0, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL forced_publish timeout: no max_valid"); end
    checks++; if (p.err !== 1'b1) begin errors++; $display("FAIL forced_err got %b want 1", p.err); end
    checks++; if (p.idx !== ei) begin errors++; $display("FAIL forced_index got %0d want %0d", p.idx, ei); end
    checks++; if (p.mag !== em) begin errors++; $display("FAIL forced_mag got %0d want %0d", p.mag, em); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL forced_latency got %0d edges want 3", lat); end
    checks++; if (low !== 4) begin errors++; $display("FAIL forced_stall got %0d cycles want 4", low); end
  endtask

  task automatic test_back_to_back();
    pub_t p0, p1; bit ok0, ok1;
    int len0, len1, ei0, ei1, acc0, acc1, fw0, fw1;
    longint em0, em1; bit ee0, ee1;
    fill(0, 2);
    fill(1, 1);
    model_frame(0, 5'd7, 127, len0, ei0, em0, ee0);
    model_frame(1, 5'd7, 127, len1, ei1, em1, ee1);
    drive_frame(0, 5'd7, 127, len0, 1'b0, 1'b0, acc0, fw0);
    drive_frame(1, 5'd7, 127, len1, 1'b0, 1'b0, acc1, fw1);
    idle();
    collect(ok0, p0);
    collect(ok1, p1);
    checks++; if (fw1 !== 4) begin errors++; $display("FAIL b2b_stall got %0d cycles want 4", fw1); end
    checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL b2b_publish got %0d/%0d publishes want 1/1", ok0, ok1); end
    checks++; if (p0.idx !== ei0) begin errors++; $display("FAIL b2b_index0 got %0d want %0d", p0.idx, ei0); end
    checks++; if (p0.mag !== em0) begin errors++; $display("FAIL b2b_mag0 got %0d want %0d", p0.mag, em0); end
    checks++; if (p0.err !== ee0) begin errors++; $display("FAIL b2b_err0 got %b want %b", p0.err, ee0); end
    checks++; if (p0.cyc - acc0 !== 3) begin errors++; $display("FAIL b2b_latency0 got %0d want 3", p0.cyc - acc0); end
    checks++; if (p1.idx !== ei1) begin errors++; $display("FAIL b2b_index1 got %0d want %0d", p1.idx, ei1); end
    checks++; if (p1.mag !== em1) begin errors++; $display("FAIL b2b_mag1 got %0d want %0d", p1.mag, em1); end
    checks++; if (p1.err !== ee1) begin errors++; $display("FAIL b2b_err1 got %b want %b", p1.err, ee1); end
    checks++; if (p1.cyc - acc1 !== 3) begin errors++; $display("FAIL b2b_latency1 got %0d want 3", p1.cyc - acc1); end
    repeat (8) @(negedge clk);
    checks++; if (pubs.size() !== 0) begin errors++; $display("FAIL b2b_extra_publish got %0d want 0", pubs.size()); end
  endtask

  task automatic test_reset_midframe();
    pub_t p; bit ok; int lat, low, ei, acc, w; longint em; bit ee;
    fill(0, 2);
    for (int k = 0; k < 300; k++) begin
      drive_beat(re_arr[0][k], im_arr[0][k], 1'b0, 5'd10, acc, w);
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", s_ready); end
    checks++; if (max_index !== '0) begin errors++; $display("FAIL midrst_index got %0d want 0", max_index); end
    checks++; if (max_mag !== '0) begin errors++; $display("FAIL midrst_mag got %0d want 0", max_mag); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (pubs.size() !== 0) begin errors++; $display("FAIL midrst_spurious_publish got %0d want 0", pubs.size()); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b want 1", s_ready); end
    fill(0, 2);
    run_frame(0, 5'd10, 1023, 1'b0, 1'b0, p, ok, lat, low, ei, em, ee);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_publish timeout: no max_valid"); end
    checks++; if (p.idx !== ei) begin errors++; $display("FAIL midrst_index_after got %0d want %0d", p.idx, ei); end
    checks++; if (p.mag !== em) begin errors++; $display("FAIL midrst_mag_after got %0d want %0d", p.mag, em); end
    checks++; if (p.err !== 1'b0) begin errors++; $display("FAIL midrst_err_after got %b want 0", p.err); end
  endtask

  task automatic test_random();
    pub_t p; bit ok; int lat, low, ei, nf, n, lp, r; longint em; bit ee;
    int nlist[7] = '{7, 8, 9, 10, 0, 31, 12};
    for (int f = 0; f < 6; f++) begin
      fill(0, (f % 2 == 0) ? 1 : 2);
      nf = nlist[$urandom_range(0, 6)];
      n = (nf >= 7 && nf <= 10) ? (1 << nf) : 1024;
      r = int'($urandom_range(0, 3));
      lp = (r < 2) ? n - 1 : (r == 2) ? int'($urandom_range(0, n - 1)) : -1;
      run_frame(0, 5'(nf), lp, 1'b1, 1'b1, p, ok, lat, low, ei, em, ee);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_publish timeout: no max_valid", f); end
      checks++; if (p.idx !== ei) begin errors++; $display("FAIL rand%0d_index got %0d want %0d (nfft=%0d last=%0d)", f, p.idx, ei, nf, lp); end
      checks++; if (p.mag !== em) begin errors++; $display("FAIL rand%0d_mag got %0d want %0d", f, p.mag, em); end
      checks++; if (p.err !== ee) begin errors++; $display("FAIL rand%0d_err got %b want %b", f, p.err, ee); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL rand%0d_latency got %0d want 3", f, lat); end
      checks++; if (low !== 4) begin errors++; $display("FAIL rand%0d_stall got %0d want 4", f, low); end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_dc_negative();
    test_tie_extreme();
    test_len_err_short();
    test_len_err_forced();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spectrum_peak_finder.md
# spectrum_peak_finder

Scans one FFT output frame per pass and finds the strongest bin in the positive-frequency half. Reports that bin's index and its magnitude-squared. Sits between the FFT core's output stream and the frequency-conversion stage: `max_index` feeds the Hz conversion directly, and `curr_nfft` is passed the same value used there.

## Interface
- `DATA_W`, 16: width of signed real/imag FFT samples
- `IDX_W`, 10: bin index width (supports N up to 1024)
- `MIN_BIN`, 1: lowest bin searched; bins below it (DC) are never reported
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `curr_nfft`  in  5  log2(N); 7..10 valid, any other value treated as 10; sampled on first beat of each frame
- `s_re`  in  DATA_W  signed real part of current bin
- `s_im`  in  DATA_W  signed imaginary part of current bin
- `s_valid`  in  1  input beat valid
- `s_last`  in  1  marks final beat of frame
- `s_ready`  out  1  block accepts beat when `s_valid & s_ready`
- `max_index`  out  IDX_W  winning bin index of last completed frame
- `max_mag`  out  2*DATA_W  winning re²+im², unsigned
- `max_valid`  out  1  one-cycle pulse: new result published
- `frame_err`  out  1  last completed frame length ≠ N

## Operation
- States: IDLE → RUN → DRAIN → PUBLISH → IDLE.
- IDLE: `s_ready`=1. First accepted beat latches the effective N from `curr_nfft`, sets the bin counter to 0, clears best and err, and enters RUN. That beat is bin 0.
- RUN: each accepted beat is bin k (counter +1). Magnitude is re²+im², computed at full width. Sign-extend before squaring; −32768² is legal.
- Search window: MIN_BIN ≤ k ≤ N/2−1. Beats outside the window are accepted and counted but never compared.
- Compare uses strict greater-than. Ties keep the lower index. If every bin in the window is zero, the result is index MIN_BIN with mag 0.
- End of frame is the first of two events:
  - accepted beat with `s_last`=1;
  - accepted beat with k=N−1.
- `frame_err`=1 in either mismatch case:
  - `s_last` arrives at k≠N−1;
  - k=N−1 is reached without `s_last`.
- A beat that arrives after forced termination without `s_last` starts a new frame.
- DRAIN: `s_ready`=0 while the magnitude/compare pipeline flushes.
- PUBLISH: outputs update, `max_valid`=1 for one cycle, then return to IDLE.
- `max_index`, `max_mag` and `frame_err` hold their value until the next PUBLISH.
- `rst` in any state discards the partial frame and returns to IDLE. Published outputs go to reset values.
- `curr_nfft` changes mid-frame are ignored until the next frame's first beat.

## Timing
- Reset values: `s_ready`=0 while `rst`=1, and 1 in the first cycle after `rst` falls. `max_index`=0, `max_mag`=0, `max_valid`=0, `frame_err`=0.
- Pipeline: P1 registers the squares, P2 registers the sum, P3 registers the compare/best.
- Sustained throughput is one beat per clock in RUN; `s_valid` gaps are allowed anywhere.
- Let the final beat be accepted on edge E:
  - `s_ready`=0 in cycles E+1..E+4;
  - `max_valid`=1 in cycle E+4, with the new outputs visible in that same cycle;
  - `s_ready`=1 again at E+5.
- Minimum inter-frame gap is therefore 4 cycles.
- `s_valid` asserted during DRAIN/PUBLISH is not accepted. The upstream holds data and must not drop the beat.

## Structure
- Shared package holds:
  - `NFFT_MIN`=7, `NFFT_MAX`=10, `NFFT_DEFAULT`=10;
  - the state enum (IDLE/RUN/DRAIN/PUBLISH);
  - `FS_HZ`=48000, shared with the Hz conversion stage.
- One sub-module: `mag_sq_pipe`. It is the 2-stage signed re²+im² pipeline with a valid/index sideband, and maps to DSP slices.
- FSM, bin counter, window check and best-register stay in the top.

## Test plan
- Single tone: nfft=10, bin 21 re=1000 im=0, all others 0, `s_last` on beat 1023 → `max_index`=21, `max_mag`=1000000, `frame_err`=0, `max_valid` exactly 4 cycles after last edge. Downstream Hz conversion gives 984.
- Negative-half and DC rejection: nfft=8, bin 0 re=30000, bin 200 re=20000, bin 50 re=500 → `max_index`=50, `max_mag`=250000.
- Tie and extreme values: nfft=7, bins 5 and 9 both re=−32768 im=−32768 → `max_index`=5, `max_mag`=2147483648.
- Length errors, both directions:
  - nfft=8 with `s_last` on beat 99 → `frame_err`=1 and publish follows;
  - nfft=7 with no `s_last` → publish after beat 127 with `frame_err`=1.
- Backpressure and reset:
  - `s_valid` held high continuously across two frames → `s_ready` low for exactly 4 cycles between them, no beat lost or duplicated;
  - `rst` pulsed at beat 300 of a 1024 frame → outputs go to 0, no `max_valid`, and the next full frame publishes correctly.
